// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, imem request/response handshake with a one-word
// hold buffer, and the IF/ID pipeline register. Optional fetch address checking via FETCH_ADEL_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        fetch_wait,
    output logic [31:0] PC_F,
    output logic [31:0] PC4_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic        valid_D,
    output logic        exc_D
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

`ifdef FETCH_ADEL_EN
    localparam logic ADEL_ON = 1'b1;
`else
    localparam logic ADEL_ON = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [31:0] hold_word_q;
    logic        hold_exc_q;
    logic        adel_f;
    logic        word_avail;
    logic        advance;
    logic        capture;
    logic [31:0] word_f;
    logic        exc_f;

    // A bad fetch address never reaches memory; it completes locally as an exception word.
    assign adel_f = ADEL_ON && (state_q == FETCH) &&
                    ((PC_F[1:0] != 2'b00) || (PC_F < IM_LO) || (PC_F > IM_HI));

    assign PC4_F      = PC_F + 32'd4;
    assign imem_addr  = PC_F;
    assign imem_req   = (state_q == FETCH) && !adel_f;
    assign fetch_wait = (state_q == FETCH) && !imem_ready && !adel_f;
    assign word_avail = (state_q == HOLD) || imem_ready || adel_f;
    assign advance    = !stall && word_avail;
    assign capture    = (state_q == FETCH) && word_avail && stall;

    always_comb begin
        word_f = imem_rdata;
        exc_f  = adel_f;
        if (state_q == HOLD) begin
            word_f = hold_word_q;
            exc_f  = hold_exc_q;
        end else if (adel_f) begin
            word_f = 32'h0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = FETCH;
        end else if (capture) begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            PC_F        <= RESET_PC;
            hold_word_q <= 32'h0;
            hold_exc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                PC_F <= NPC;
            end
            if (capture) begin
                hold_word_q <= word_f;
                hold_exc_q  <= exc_f;
            end
        end
    end

    // IF/ID boundary: flush wins over both stall and advance, but only for this register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instr_D <= 32'h0;
            PC_D    <= 32'h0;
            PC4_D   <= 32'h0;
            valid_D <= 1'b0;
            exc_D   <= 1'b0;
        end else if (flush) begin
            Instr_D <= 32'h0;
            valid_D <= 1'b0;
            exc_D   <= 1'b0;
        end else if (advance) begin
            Instr_D <= word_f;
            PC_D    <= PC_F;
            PC4_D   <= PC4_F;
            valid_D <= 1'b1;
            exc_D   <= exc_f;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; memory returns addr ^ A5A55A5A.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [31:0] NPC;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        fetch_wait;
    logic [31:0] PC_F, PC4_F, Instr_D, PC_D, PC4_D;
    logic        valid_D, exc_D;

    logic        stall_tb, auto_stall, npc_ovr_en;
    logic [31:0] npc_ovr;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign NPC        = npc_ovr_en ? npc_ovr : PC4_F;
    assign stall      = stall_tb | (auto_stall & fetch_wait);
    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    if_stage dut (
        .clk(clk), .reset(reset), .NPC(NPC), .stall(stall), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .fetch_wait(fetch_wait), .PC_F(PC_F), .PC4_F(PC4_F),
        .Instr_D(Instr_D), .PC_D(PC_D), .PC4_D(PC4_D), .valid_D(valid_D), .exc_D(exc_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        stall_tb = 0; auto_stall = 0; flush = 0; imem_ready = 1;
        npc_ovr_en = 0; npc_ovr = 32'h0;
        reset = 0;
        step();
        reset = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (PC_F !== 32'h3000) begin failures++; $display("FAIL rst_pc_f got=%h exp=%h", PC_F, 32'h3000); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_req got=%b exp=1", imem_req); end
        checks++; if ({Instr_D, PC_D, PC4_D} !== 96'h0) begin failures++; $display("FAIL rst_ifid got=%h exp=0", {Instr_D, PC_D, PC4_D}); end
        checks++; if ({valid_D, exc_D} !== 2'b00) begin failures++; $display("FAIL rst_valid_exc got=%b exp=00", {valid_D, exc_D}); end
        step(); step();
        imem_ready = 0;
        #2;
        reset = 0;
        #1;
        checks++; if (PC_F !== 32'h3000 || valid_D !== 1'b0) begin failures++; $display("FAIL rst_async got pc=%h v=%b exp pc=3000 v=0", PC_F, valid_D); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_async_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_sequential();
        apply_reset();
        step();
        checks++; if (PC_F !== 32'h3004) begin failures++; $display("FAIL seq_pc_f1 got=%h exp=%h", PC_F, 32'h3004); end
        checks++; if (PC_D !== 32'h3000 || PC4_D !== 32'h3004) begin failures++; $display("FAIL seq_pc_d1 got=%h/%h exp=3000/3004", PC_D, PC4_D); end
        checks++; if (Instr_D !== mem_word(32'h3000) || valid_D !== 1'b1) begin failures++; $display("FAIL seq_instr1 got=%h v=%b exp=%h v=1", Instr_D, valid_D, mem_word(32'h3000)); end
        step();
        checks++; if (PC_F !== 32'h3008 || PC_D !== 32'h3004) begin failures++; $display("FAIL seq_pc2 got=%h/%h exp=3008/3004", PC_F, PC_D); end
        checks++; if (Instr_D !== mem_word(32'h3004)) begin failures++; $display("FAIL seq_instr2 got=%h exp=%h", Instr_D, mem_word(32'h3004)); end
    endtask

    task automatic test_wait();
        apply_reset();
        auto_stall = 1;
        step();
        imem_ready = 0;
        #1;
        checks++; if (fetch_wait !== 1'b1) begin failures++; $display("FAIL wait_flag0 got=%b exp=1", fetch_wait); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (PC_D !== 32'h3000 || PC_F !== 32'h3004) begin failures++; $display("FAIL wait_hold%0d got=%h/%h exp=3000/3004", i, PC_D, PC_F); end
            checks++; if (fetch_wait !== 1'b1) begin failures++; $display("FAIL wait_flag%0d got=%b exp=1", i + 1, fetch_wait); end
        end
        imem_ready = 1;
        #1;
        checks++; if (fetch_wait !== 1'b0) begin failures++; $display("FAIL wait_clear got=%b exp=0", fetch_wait); end
        step();
        checks++; if (PC_D !== 32'h3004 || Instr_D !== mem_word(32'h3004)) begin failures++; $display("FAIL wait_done got=%h/%h exp=3004/%h", PC_D, Instr_D, mem_word(32'h3004)); end
        checks++; if (PC_F !== 32'h3008) begin failures++; $display("FAIL wait_pc_f got=%h exp=3008", PC_F); end
    endtask

    task automatic test_hold();
        apply_reset();
        step(); step();
        stall_tb = 1;
        step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req got=%b exp=0", imem_req); end
        checks++; if (PC_F !== 32'h3008 || PC_D !== 32'h3004) begin failures++; $display("FAIL hold_frozen got=%h/%h exp=3008/3004", PC_F, PC_D); end
        imem_ready = 0;
        step(); step();
        checks++; if (imem_req !== 1'b0 || fetch_wait !== 1'b0) begin failures++; $display("FAIL hold_idle got req=%b wait=%b exp=0/0", imem_req, fetch_wait); end
        checks++; if (PC_F !== 32'h3008 || PC_D !== 32'h3004) begin failures++; $display("FAIL hold_still got=%h/%h exp=3008/3004", PC_F, PC_D); end
        stall_tb = 0;
        step();
        checks++; if (PC_D !== 32'h3008 || Instr_D !== mem_word(32'h3008)) begin failures++; $display("FAIL hold_release got=%h/%h exp=3008/%h", PC_D, Instr_D, mem_word(32'h3008)); end
        checks++; if (PC_F !== 32'h300C || imem_req !== 1'b1) begin failures++; $display("FAIL hold_next got=%h req=%b exp=300c req=1", PC_F, imem_req); end
    endtask

    task automatic test_redirect();
        apply_reset();
        step(); step(); step();
        npc_ovr_en = 1; npc_ovr = 32'h3100;
        step();
        npc_ovr_en = 0;
        checks++; if (PC_D !== 32'h300C || PC_F !== 32'h3100) begin failures++; $display("FAIL redir_slot got=%h/%h exp=300c/3100", PC_D, PC_F); end
        step();
        checks++; if (PC_D !== 32'h3100 || Instr_D !== mem_word(32'h3100) || PC_F !== 32'h3104) begin failures++; $display("FAIL redir_target got=%h/%h/%h exp=3100/%h/3104", PC_D, Instr_D, PC_F, mem_word(32'h3100)); end
    endtask

    task automatic test_flush();
        apply_reset();
        step(); step();
        stall_tb = 1; flush = 1;
        step();
        checks++; if (Instr_D !== 32'h0 || valid_D !== 1'b0) begin failures++; $display("FAIL flush_stall got=%h v=%b exp=0 v=0", Instr_D, valid_D); end
        checks++; if (PC_F !== 32'h3008 || PC_D !== 32'h3004) begin failures++; $display("FAIL flush_stall_pc got=%h/%h exp=3008/3004", PC_F, PC_D); end
        stall_tb = 0;
        step();
        flush = 0;
        checks++; if (valid_D !== 1'b0 || PC_D !== 32'h3004 || PC_F !== 32'h300C) begin failures++; $display("FAIL flush_adv got v=%b %h/%h exp v=0 3004/300c", valid_D, PC_D, PC_F); end
        step();
        checks++; if (valid_D !== 1'b1 || PC_D !== 32'h300C) begin failures++; $display("FAIL flush_resume got v=%b %h exp v=1 300c", valid_D, PC_D); end
    endtask

    task automatic test_wrap();
        apply_reset();
        npc_ovr_en = 1; npc_ovr = 32'hFFFF_FFFC;
        step();
        npc_ovr_en = 0;
        checks++; if (PC_F !== 32'hFFFF_FFFC || PC4_F !== 32'h0) begin failures++; $display("FAIL wrap_f got=%h/%h exp=fffffffc/0", PC_F, PC4_F); end
        step();
        checks++; if (PC_D !== 32'hFFFF_FFFC || PC4_D !== 32'h0 || PC_F !== 32'h0) begin failures++; $display("FAIL wrap_d got=%h/%h/%h exp=fffffffc/0/0", PC_D, PC4_D, PC_F); end
    endtask

    task automatic test_adel();
        apply_reset();
        npc_ovr_en = 1; npc_ovr = 32'h3002;
        step();
        npc_ovr_en = 0;
`ifdef FETCH_ADEL_EN
        imem_ready = 0;
        #1;
        checks++; if (imem_req !== 1'b0 || fetch_wait !== 1'b0) begin failures++; $display("FAIL adel_req got req=%b wait=%b exp=0/0", imem_req, fetch_wait); end
        step();
        checks++; if (exc_D !== 1'b1 || Instr_D !== 32'h0 || PC_D !== 32'h3002 || valid_D !== 1'b1) begin failures++; $display("FAIL adel_ifid got exc=%b %h/%h v=%b exp 1 0/3002 v=1", exc_D, Instr_D, PC_D, valid_D); end
`else
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3002) begin failures++; $display("FAIL noadel_req got req=%b addr=%h exp=1/3002", imem_req, imem_addr); end
        step();
        checks++; if (exc_D !== 1'b0 || Instr_D !== mem_word(32'h3002) || PC_D !== 32'h3002) begin failures++; $display("FAIL noadel_ifid got exc=%b %h/%h exp 0 %h/3002", exc_D, Instr_D, PC_D, mem_word(32'h3002)); end
`endif
    endtask

    initial begin
        reset = 0; stall_tb = 0; auto_stall = 0; flush = 0; imem_ready = 1;
        npc_ovr_en = 0; npc_ovr = 32'h0;
        test_reset();
        test_sequential();
        test_wait();
        test_hold();
        test_redirect();
        test_flush();
        test_wrap();
        test_adel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
